mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single byte-addressed main memory port between the fetch requester (I) and the
//  load/store requester (D) of the RV32I pipeline. Arbitrates, latches one request, then drives
//  memRead/memWrite/funct3/addr/writeData for exactly one cycle and registers the response.
//  Rejects out-of-range and illegal-funct3 accesses before they reach memory.
// PARAMETERS
//  MEM_BYTES     4096  memory size in bytes; an access is legal only if addr+size-1 < MEM_BYTES
//  STARVE_LIMIT  3     max consecutive D grants while I is pending before I is forced through
// PORTS
//  clk          in   1   system clock, all state on posedge
//  rst_n        in   1   asynchronous active-low reset
//  i_req        in   1   fetch request (word read; funct3 fixed 3'b010)
//  i_addr       in   32  fetch byte address
//  i_ready      out  1   request accepted this cycle (comb., only in IDLE)
//  i_valid      out  1   one-cycle response strobe
//  i_rdata      out  32  fetched word (0 on error)
//  i_err        out  1   qualifies i_valid: range error
//  d_req        in   1   load/store request
//  d_we         in   1   1 = store, 0 = load
//  d_funct3     in   3   RV32I width/sign code
//  d_addr       in   32  byte address
//  d_wdata      in   32  store data
//  d_ready      out  1   request accepted this cycle (comb., only in IDLE)
//  d_valid      out  1   one-cycle response strobe (loads and stores)
//  d_rdata      out  32  load data (0 for stores and errors)
//  d_err        out  1   qualifies d_valid: range or funct3 error
//  mem_read     out  1   to memory memRead
//  mem_write    out  1   to memory memWrite
//  mem_funct3   out  3   to memory funct3
//  mem_addr     out  32  to memory addr
//  mem_wdata    out  32  to memory writeData
//  mem_data     in   32  from memory data (combinational read)
// BEHAVIOUR
//  - Reset: state IDLE, starve_cnt 0, all *_ready/*_valid/*_err/mem_read/mem_write 0, all data/addr
//    regs 0. Async: asserting rst_n low in ACCESS drops mem_write immediately; no response issued.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE; error path IDLE -> RESP -> IDLE.
//  - IDLE: if d_req && (!i_req || starve_cnt != STARVE_LIMIT) grant D; else if i_req grant I.
//    Grant = ready high that cycle; requester fields latched at that edge. Requesters hold fields
//    stable while req high; dropping req before ready has no effect.
//  - starve_cnt: +1 on a D grant while i_req=1; cleared on I grant or when i_req=0 in IDLE;
//    saturates at STARVE_LIMIT.
//  - Legality at grant: size 1/2/4 from funct3[1:0]; end = {1'b0,addr}+size-1 in 33 bits (no wrap);
//    illegal if end >= MEM_BYTES. D loads allow funct3 000,001,010,100,101; stores 000,001,010.
//    Illegal -> skip ACCESS, RESP with err=1, rdata=0, no mem strobe ever raised.
//  - ACCESS (1 cycle): mem_read = !we, mem_write = we, mem_funct3/addr/wdata from latched regs;
//    mem_data captured into the granted requester's rdata at the closing edge (store: rdata 0).
//  - RESP (1 cycle): granted requester's valid=1 (+err); the other stays 0. Then IDLE.
//  - Outside ACCESS mem_read=mem_write=0; mem_addr/funct3/wdata hold last latched values.
//  - Latency: ready at cycle N -> valid at N+2 (legal) or N+1 (error). One op per 3 cycles max.
//  - rdata/err hold until the next response for that requester; only valid is a pulse.
// TESTING
//  1 Reset: rst_n=0 with random inputs -> all ready/valid/err/mem strobes 0; release -> IDLE.
//  2 D store SW addr 0x10 wdata 0xDEADBEEF granted cycle N -> mem_write=1, mem_addr=0x10,
//    mem_funct3=010 at N+1 only; d_valid=1,d_err=0,d_rdata=0 at N+2.
//  3 I fetch addr 0x40, stub mem_data=0x11223344 during ACCESS -> i_valid at N+2,
//    i_rdata=0x11223344, mem_read high exactly one cycle.
//  4 STARVE_LIMIT=2, i_req and d_req held high -> grant order D,D,I,D,D,I; i_req=0 -> D only.
//  5 MEM_BYTES=4096: D LW 0xFFE, LH 0xFFF, I fetch 0xFFFFFFFD -> err=1 at N+1, mem strobes never high;
//    LW 0xFFC -> legal.
//  6 D store funct3=100 -> d_err at N+1, no mem_write; rst_n low during ACCESS of a store ->
//    mem_write drops same cycle, no d_valid follows.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressed memory port between the fetch (I) and load/store (D) requesters.
// Grants one request at a time, screens illegal accesses and registers the response.
module mem_port_arbiter #(
    parameter int unsigned MEM_BYTES    = 4096,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_data,
    output logic [1:0]  dbg_state
);

    localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    localparam logic [32:0] MEM_END = 33'(MEM_BYTES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          gnt_d_q, gnt_d_d;
    logic          we_q, we_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic          i_valid_q, i_valid_d;
    logic          i_err_q, i_err_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic          d_valid_q, d_valid_d;
    logic          d_err_q, d_err_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic          d_win, d_grant, i_grant;
    logic          sel_we, f3_ok, sel_legal;
    logic [2:0]    sel_f3, sel_size;
    logic [31:0]   sel_addr;
    logic [32:0]   sel_end;

    // D wins unless I is pending and has already been passed over STARVE_LIMIT times.
    assign d_win   = d_req && (!i_req || starve_q != LIMIT);
    assign d_grant = rst_n && state_q == IDLE && d_win;
    assign i_grant = rst_n && state_q == IDLE && i_req && !d_win;

    always_comb begin
        sel_we   = d_grant & d_we;
        sel_f3   = d_grant ? d_funct3 : 3'b010;
        sel_addr = d_grant ? d_addr : i_addr;
        case (sel_f3[1:0])
            2'b00:   sel_size = 3'd1;
            2'b01:   sel_size = 3'd2;
            default: sel_size = 3'd4;
        endcase
        // 33-bit end address so a fetch near 0xFFFFFFFF cannot wrap into range.
        sel_end = {1'b0, sel_addr} + {30'd0, sel_size} - 33'd1;
        if (!d_grant)
            f3_ok = 1'b1;
        else if (d_we)
            f3_ok = d_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            f3_ok = d_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        sel_legal = f3_ok && (sel_end < MEM_END);
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        gnt_d_d     = gnt_d_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        i_valid_d   = 1'b0;
        i_err_d     = i_err_q;
        i_rdata_d   = i_rdata_q;
        d_valid_d   = 1'b0;
        d_err_d     = d_err_q;
        d_rdata_d   = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (d_grant || i_grant) begin
                    gnt_d_d  = d_grant;
                    we_d     = sel_we;
                    funct3_d = sel_f3;
                    addr_d   = sel_addr;
                    if (d_grant)
                        wdata_d = d_wdata;
                    if (sel_legal) begin
                        state_d     = ACCESS;
                        mem_read_d  = !sel_we;
                        mem_write_d = sel_we;
                    end else begin
                        state_d = RESP;
                        if (d_grant) begin
                            d_valid_d = 1'b1;
                            d_err_d   = 1'b1;
                            d_rdata_d = '0;
                        end else begin
                            i_valid_d = 1'b1;
                            i_err_d   = 1'b1;
                            i_rdata_d = '0;
                        end
                    end
                end
                if (d_grant && i_req)
                    starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + CW'(1);
                else if (i_grant || !i_req)
                    starve_d = '0;
            end
            ACCESS: begin
                state_d = RESP;
                if (gnt_d_q) begin
                    d_valid_d = 1'b1;
                    d_err_d   = 1'b0;
                    d_rdata_d = we_q ? '0 : mem_data;
                end else begin
                    i_valid_d = 1'b1;
                    i_err_d   = 1'b0;
                    i_rdata_d = mem_data;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            gnt_d_q     <= 1'b0;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_valid_q   <= 1'b0;
            i_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            gnt_d_q     <= gnt_d_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            i_valid_q   <= i_valid_d;
            i_err_q     <= i_err_d;
            i_rdata_q   <= i_rdata_d;
            d_valid_q   <= d_valid_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign i_ready    = i_grant;
    assign d_ready    = d_grant;
    assign i_valid    = i_valid_q;
    assign i_err      = i_err_q;
    assign i_rdata    = i_rdata_q;
    assign d_valid    = d_valid_q;
    assign d_err      = d_err_q;
    assign d_rdata    = d_rdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_funct3 = funct3_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign dbg_state  = state_q;

endmodule
